regfile_wb_arbiter: RTL
=======================

# regfile_wb_arbiter

Writeback controller for the 32x32 register file: it shares the file's single write port between two writeback requesters (ALU and load unit) using a valid/ready handshake. It drives the file's Din/rd/enable/read_write port through one registered stage and keeps a 32-bit pending-write scoreboard so issue logic can detect RAW hazards. It sits between the execute/memory stages and the register file; the read ports (rs1/rs2 -> A/B) bypass it.

## Interface
Parameters:
- DATA_W, 32, register data width
- ADDR_W, 5, register index width (32 registers)

Ports:
- clock  in  1  single clock; all state updates on rising edge
- reset  in  1  asynchronous, active-low reset
- req_valid  in  2  per-requester write request (bit 0 ALU, bit 1 load)
- req_rd  in  2xADDR_W  destination register per requester
- req_data  in  2xDATA_W  write data per requester
- req_ready  out  2  grant; handshake completes when valid & ready at clock edge
- claim_valid  in  1  issue stage reserves a destination
- claim_rd  in  ADDR_W  register being reserved
- busy  out  32  pending-write scoreboard, bit i = register i awaiting writeback
- rf_din  out  DATA_W  to register file Din
- rf_rd  out  ADDR_W  to register file rd
- rf_enable  out  1  to register file enable
- rf_read_write  out  1  to register file read_write (1 = write)
- err_unclaimed  out  1  sticky: write accepted to a register whose busy bit was clear

## Operation
- Arbitration: combinational each cycle; at most one req_ready bit high; req_ready[i] only when req_valid[i].
- One valid requester: it is granted.
- Both valid: with ROUND_ROBIN_EN, the requester not granted last time wins; a last_grant bit updates on every completed handshake (reset value 0, so req 1 wins the first tie); without it, req 0 always wins.
- Accepted write with rd != 0: rf_din/rf_rd capture the data, rf_read_write = 1 for exactly the following cycle.
- Accepted write with rd == 0: handshake completes, no file write (rf_read_write stays 0), no error.
- Idle cycles: rf_read_write = 0, rf_rd/rf_din hold the last values; rf_enable = 1 at all times out of reset.
- Scoreboard: claim_valid with claim_rd != 0 sets busy[claim_rd]; an accepted write clears busy[req_rd]; busy[0] is constant 0.
- Same edge set and clear on the same index: set wins (newer instruction owns the register).
- Claim on an already-busy index: stays set, no error.
- err_unclaimed is set when an accepted write with rd != 0 finds busy[rd] == 0; it clears only on reset.

## Timing
- Reset (asynchronous, low): busy = 0, rf_din = 0, rf_rd = 0, rf_enable = 0, rf_read_write = 0, err_unclaimed = 0, last_grant = 0; req_ready = 0 while reset is low.
- Grant latency 0: req_ready is valid in the same cycle as req_valid.
- Write latency 1: handshake at edge N gives the file write at edge N+1; the data is readable on A/B after edge N+1.
- Busy clears at edge N; throughput is one write per cycle, with no bubbles between back-to-back grants.
- Requesters hold valid/rd/data stable until ready; a dropped request does not corrupt state.
- Reset asserted mid-write: the pending registered write is discarded, the scoreboard is cleared, and no rf write occurs.

## Configuration
- ROUND_ROBIN_EN defined: two-way round-robin tie-break with the last_grant register.
- Not defined: fixed priority to req 0. last_grant is absent, and req 1 may starve under continuous req 0 traffic, which is acceptable for single-issue pipelines.

## Structure
- Package regfile_ctrl_pkg: DATA_W, ADDR_W, NUM_REGS = 32, requester index constants REQ_ALU = 0 and REQ_LOAD = 1.
- Sub-module rr_arb2: 2-input arbiter (valid in, one-hot grant out, advance input); round-robin or fixed priority selected by ROUND_ROBIN_EN.
- Top level holds the scoreboard, output register and error flag.

## Test plan
- Reset low with req_valid = 2'b11: req_ready = 0 and all outputs 0. Release reset: rf_enable = 1 and busy = 0.
- Claim rd = 3, then ALU writes 32'h12345678 to rd 3: ready the same cycle, rf_read_write = 1 and rf_rd = 3 the next cycle, busy[3] cleared, A reads 32'h12345678 with rs1 = 3.
- Claim rd 10 and rd 17, then both requesters valid for 4 cycles (ALU rd 10, load rd 17). With ROUND_ROBIN_EN: grants 1,0,1,0. Without it: 0,0,0,0 and load waits.
- Write rd 0 with data 32'hA5A5A5A5: handshake completes, rf_read_write stays 0, err_unclaimed stays 0.
- Claim rd 24 on the same edge that the load write to rd 24 is accepted: busy[24] remains 1. Write rd 25 with no prior claim: err_unclaimed = 1 and stays set.
- Assert reset the cycle after a handshake: no rf write, busy = 0, err_unclaimed = 0.

Source files
------------

// File: rtl/regfile_ctrl_pkg.sv
// Shared constants for the register-file writeback path.
//   DATA_W / ADDR_W : register data width and register index width
//   NUM_REGS        : number of architectural registers (width of busy)
//   REQ_ALU/REQ_LOAD: bit positions of the two writeback requesters
package regfile_ctrl_pkg;
  localparam int DATA_W   = 32;
  localparam int ADDR_W   = 5;
  localparam int NUM_REGS = 32;
  localparam int REQ_ALU  = 0;
  localparam int REQ_LOAD = 1;
endpackage

// File: rtl/regfile_wb_arbiter_rr_arb2.sv
// rr_arb2: two-input arbiter producing a one-hot grant from two valids.
// Build option: ROUND_ROBIN_EN
//   defined   : ties go to the requester not granted last; last_grant_q
//               updates on every completed handshake (advance_i).
//   undefined : fixed priority, requester 0 wins ties; no state, no clock.
// Ports:
//   clk_i, rst_ni (ROUND_ROBIN_EN only) : clock, async active-low reset
//   advance_i     (ROUND_ROBIN_EN only) : a grant was consumed this cycle
//   valid_i [1:0] : request valids
//   grant_o [1:0] : one-hot grant, only to a valid requester
module rr_arb2
  import regfile_ctrl_pkg::*;
(
`ifdef ROUND_ROBIN_EN
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       advance_i,
`endif
  input  logic [1:0] valid_i,
  output logic [1:0] grant_o
);

`ifdef ROUND_ROBIN_EN
  logic last_grant_q;
  logic last_grant_d;

  always_comb begin
    grant_o = 2'b00;
    case (valid_i)
      2'b01:   grant_o = 2'b01;
      2'b10:   grant_o = 2'b10;
      // Reset value 0 lets the load requester win the first tie.
      2'b11:   grant_o = last_grant_q ? 2'b01 : 2'b10;
      default: grant_o = 2'b00;
    endcase
  end

  assign last_grant_d = advance_i ? grant_o[REQ_LOAD] : last_grant_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) last_grant_q <= 1'b0;
    else         last_grant_q <= last_grant_d;
  end
`else
  always_comb begin
    grant_o = 2'b00;
    if (valid_i[REQ_ALU])       grant_o[REQ_ALU]  = 1'b1;
    else if (valid_i[REQ_LOAD]) grant_o[REQ_LOAD] = 1'b1;
  end
`endif

endmodule

// File: rtl/regfile_wb_arbiter.sv
// regfile_wb_arbiter: shares the register file's single write port between
// the ALU (requester 0) and load unit (requester 1) with valid/ready, drives
// the file write port through one register stage, and keeps a pending-write
// scoreboard for RAW hazard detection.
// Build option: ROUND_ROBIN_EN (round-robin tie-break, else fixed to ALU).
// Ports:
//   clock, reset (async, active-low)
//   req_valid[1:0], req_rd[2*ADDR_W], req_data[2*DATA_W] : write requests
//   req_ready[1:0]  : grant, one-hot at most, combinational
//   claim_valid, claim_rd : issue stage reserves a destination register
//   busy[31:0]      : bit i set while register i awaits writeback
//   rf_din, rf_rd, rf_enable, rf_read_write : register file write port
//   err_unclaimed   : sticky, a write landed on a register that was not busy
module regfile_wb_arbiter #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [1:0]            req_valid,
  input  logic [2*ADDR_W-1:0]   req_rd,
  input  logic [2*DATA_W-1:0]   req_data,
  output logic [1:0]            req_ready,
  input  logic                  claim_valid,
  input  logic [ADDR_W-1:0]     claim_rd,
  output logic [31:0]           busy,
  output logic [DATA_W-1:0]     rf_din,
  output logic [ADDR_W-1:0]     rf_rd,
  output logic                  rf_enable,
  output logic                  rf_read_write,
  output logic                  err_unclaimed
);
  import regfile_ctrl_pkg::*;

  logic [1:0]          grant;
  logic                hs;
  logic                sel_load;
  logic [ADDR_W-1:0]   sel_rd;
  logic [DATA_W-1:0]   sel_data;
  logic                wr_en;

  logic [NUM_REGS-1:0] busy_q, busy_d;
  logic [DATA_W-1:0]   rf_din_q, rf_din_d;
  logic [ADDR_W-1:0]   rf_rd_q, rf_rd_d;
  logic                rf_we_q;
  logic                rf_en_q;
  logic                err_q, err_d;

  rr_arb2 u_arb (
`ifdef ROUND_ROBIN_EN
    .clk_i     (clock),
    .rst_ni    (reset),
    .advance_i (hs),
`endif
    .valid_i   (req_valid),
    .grant_o   (grant)
  );

  // No grant may escape while reset is held, even though arbitration is
  // purely combinational.
  assign req_ready = grant & {2{reset}};

  assign hs       = |(req_valid & req_ready);
  assign sel_load = req_ready[REQ_LOAD];
  assign sel_rd   = sel_load ? req_rd[REQ_LOAD*ADDR_W +: ADDR_W]
                             : req_rd[REQ_ALU*ADDR_W +: ADDR_W];
  assign sel_data = sel_load ? req_data[REQ_LOAD*DATA_W +: DATA_W]
                             : req_data[REQ_ALU*DATA_W +: DATA_W];
  // Writes to x0 complete the handshake but never reach the file.
  assign wr_en    = hs && (sel_rd != '0);

  always_comb begin
    rf_din_d = rf_din_q;
    rf_rd_d  = rf_rd_q;
    if (wr_en) begin
      rf_din_d = sel_data;
      rf_rd_d  = sel_rd;
    end
  end

  // Clear first, then set: a claim on the same edge as the retiring write
  // belongs to a newer instruction and must survive.
  always_comb begin
    busy_d = busy_q;
    if (hs) busy_d[sel_rd] = 1'b0;
    if (claim_valid && (claim_rd != '0)) busy_d[claim_rd] = 1'b1;
    busy_d[0] = 1'b0;
  end

  assign err_d = err_q | (wr_en & ~busy_q[sel_rd]);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      busy_q   <= '0;
      rf_din_q <= '0;
      rf_rd_q  <= '0;
      rf_we_q  <= 1'b0;
      rf_en_q  <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      busy_q   <= busy_d;
      rf_din_q <= rf_din_d;
      rf_rd_q  <= rf_rd_d;
      rf_we_q  <= wr_en;
      rf_en_q  <= 1'b1;
      err_q    <= err_d;
    end
  end

  assign busy          = busy_q;
  assign rf_din        = rf_din_q;
  assign rf_rd         = rf_rd_q;
  assign rf_enable     = rf_en_q;
  assign rf_read_write = rf_we_q;
  assign err_unclaimed = err_q;

endmodule
